add_nrsr: RTL and testbench
===========================

ADD_NRSR -- requirements
Module: add_nrsr

Interface
REQ-001 Parameter: DATA_W, default 14, bit width of one pixel sample.
REQ-002 Parameter: LANES, default 4, number of pixels per clock, lane 0 = leftmost.
REQ-003 Parameter: NR_EN, default 1, 1 = horizontal noise reduction active, 0 = bypass with identical latency.
REQ-004 Port: clk_72m  input  1  sensor pixel clock, all logic on rising edge.
REQ-005 Port: xreset  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 Port: sens_h_start_in  input  1  one-cycle pulse marking line start.
REQ-007 Port: sens_v_start_in  input  1  one-cycle pulse marking frame start.
REQ-008 Port: sens_h_blank_in  input  1  high during horizontal blanking.
REQ-009 Port: sens_v_blank_in  input  1  high during vertical blanking.
REQ-010 Port: sens_pix_data_in  input  [LANES-1:0][DATA_W-1:0]  pixel samples, unsigned.
REQ-011 Ports: sens_h_start_out, sens_v_start_out, sens_h_blank_out, sens_v_blank_out  output  1 each  delayed sync flags.
REQ-012 Port: sens_pix_data_out  output  [LANES-1:0][DATA_W-1:0]  processed pixels.

Function
REQ-013 Input beat valid SHALL be defined as !sens_h_blank_in && !sens_v_blank_in.
REQ-014 All outputs SHALL be registered; latency input -> output SHALL be exactly 2 clk_72m cycles for flags and data alike, no bubbles, no backpressure.
REQ-015 Flags SHALL pass through a pure 2-stage delay, bit-exact.
REQ-016 With NR_EN=1, for valid beat, out[k] SHALL equal (p[k] + p[k-1] + 1) >> 1, computed at DATA_W+1 bits; the result never overflows DATA_W.
REQ-017 For k>0, p[k-1] SHALL be lane k-1 of the same beat; for k=0, p[-1] SHALL be lane LANES-1 of the previous valid beat of the same line.
REQ-018 First valid beat after sens_h_start_in, or after any blank-to-valid transition, SHALL use p[-1] = p[0] (lane 0 output equals its input).
REQ-019 Held lane LANES-1 value SHALL update only on valid beats; blanking SHALL not alter it except for the line-start marking in REQ-018.
REQ-020 Non-valid beats SHALL output sens_pix_data_out = 0.
REQ-021 With NR_EN=0, sens_pix_data_out SHALL equal input data delayed 2 cycles (zero during blank).
REQ-022 Simultaneous h_start and v_start SHALL both propagate; v_start additionally SHALL reset line-start state as h_start does.
REQ-023 Expected size 120-400 lines; no memories, no division.

Reset
REQ-024 While xreset=0 (asynchronous assertion): sens_h_start_out=0, sens_v_start_out=0, sens_h_blank_out=1, sens_v_blank_out=1, sens_pix_data_out=0, pipeline and held lane value cleared, line-start flag set.
REQ-025 Release SHALL be synchronous to clk_72m; first input sampled on first rising edge after release appears 2 cycles later.
REQ-026 Reset mid-line SHALL discard line context; next valid beat SHALL be treated as line start.

Verification
REQ-027 Reset held 1 us then released with blanks high -> outputs stay blank=1, data 0, start pulses 0.
REQ-028 h_start pulse at cycle N -> sens_h_start_out high exactly at cycle N+2 for one cycle; same for v_start.
REQ-029 First valid beat {100,200,300,400} (lane0..3) -> output {100,150,250,350} two cycles later.
REQ-030 Next beat {500,500,500,500} -> output {450,500,500,500} (lane0 uses previous lane3=400).
REQ-031 Beat {16383,16383,16382,0} after lane3=16383 -> {16383,16383,16383,8191}, no overflow.
REQ-032 NR_EN=0, random valid data with blanking gaps -> output equals input delayed 2 cycles, zero during blank.

Source files
------------

// File: rtl/add_nrsr.sv
// add_nrsr: horizontal noise reduction on a multi-lane sensor pixel stream.
// Each output lane is the rounded average of its input lane and the lane to its left.
// Lane 0 uses lane LANES-1 of the previous valid beat of the same line.
// Flags and data share a fixed 2-cycle latency. There is no backpressure.
//
// Parameters:
//   DATA_W  bits per pixel sample
//   LANES   pixels per clock, lane 0 = leftmost
//   NR_EN   1 = filter active, 0 = bypass with the same latency
// Ports:
//   clk_72m            pixel clock, rising edge
//   xreset             asynchronous active-low reset
//   sens_*_in          sync flags and pixel data from the sensor
//   sens_*_out         the same flags delayed 2 cycles, and the processed pixels
//                      (zero during blanking)
module add_nrsr #(
  parameter int unsigned DATA_W = 14,
  parameter int unsigned LANES  = 4,
  parameter bit          NR_EN  = 1'b1
) (
  input  logic                          clk_72m,
  input  logic                          xreset,
  input  logic                          sens_h_start_in,
  input  logic                          sens_v_start_in,
  input  logic                          sens_h_blank_in,
  input  logic                          sens_v_blank_in,
  input  logic [LANES-1:0][DATA_W-1:0]  sens_pix_data_in,
  output logic                          sens_h_start_out,
  output logic                          sens_v_start_out,
  output logic                          sens_h_blank_out,
  output logic                          sens_v_blank_out,
  output logic [LANES-1:0][DATA_W-1:0]  sens_pix_data_out
);

  logic                         beat_valid;
  logic                         line_start;
  logic [DATA_W-1:0]            prev [LANES];
  logic [DATA_W:0]              sum  [LANES];
  logic [LANES-1:0][DATA_W-1:0] nr_data;
  logic [LANES-1:0][DATA_W-1:0] data_d;

  // Cross-beat context
  logic [DATA_W-1:0]            held_q;
  logic                         line_start_q;

  // Stage 1 registers
  logic                         h_start_q, v_start_q, h_blank_q, v_blank_q;
  logic [LANES-1:0][DATA_W-1:0] data_q;

  always_comb begin
    beat_valid = !sens_h_blank_in && !sens_v_blank_in;
    // A start pulse in the same cycle as a valid beat also makes that beat a line start.
    line_start = line_start_q | sens_h_start_in | sens_v_start_in;

    // At line start, lane 0 is averaged with itself, so it passes through unchanged.
    prev[0] = line_start ? sens_pix_data_in[0] : held_q;
    for (int k = 1; k < LANES; k++) begin
      prev[k] = sens_pix_data_in[k-1];
    end

    nr_data = '0;
    for (int k = 0; k < LANES; k++) begin
      // Compute at DATA_W+1 bits. The rounded average always fits back into DATA_W bits.
      sum[k]     = {1'b0, sens_pix_data_in[k]} + {1'b0, prev[k]} + (DATA_W+1)'(1);
      nr_data[k] = sum[k][DATA_W:1];
    end

    if (!beat_valid) begin
      data_d = '0;
    end else if (NR_EN) begin
      data_d = nr_data;
    end else begin
      data_d = sens_pix_data_in;
    end
  end

  always_ff @(posedge clk_72m or negedge xreset) begin
    if (!xreset) begin
      held_q            <= '0;
      line_start_q      <= 1'b1;
      h_start_q         <= 1'b0;
      v_start_q         <= 1'b0;
      h_blank_q         <= 1'b1;
      v_blank_q         <= 1'b1;
      data_q            <= '0;
      sens_h_start_out  <= 1'b0;
      sens_v_start_out  <= 1'b0;
      sens_h_blank_out  <= 1'b1;
      sens_v_blank_out  <= 1'b1;
      sens_pix_data_out <= '0;
    end else begin
      // Any non-valid beat re-arms the line start. The held lane only moves on valid beats.
      line_start_q <= !beat_valid;
      if (beat_valid) begin
        held_q <= sens_pix_data_in[LANES-1];
      end
      h_start_q         <= sens_h_start_in;
      v_start_q         <= sens_v_start_in;
      h_blank_q         <= sens_h_blank_in;
      v_blank_q         <= sens_v_blank_in;
      data_q            <= data_d;
      sens_h_start_out  <= h_start_q;
      sens_v_start_out  <= v_start_q;
      sens_h_blank_out  <= h_blank_q;
      sens_v_blank_out  <= v_blank_q;
      sens_pix_data_out <= data_q;
    end
  end

endmodule

// File: tb/tb_add_nrsr.sv
module tb_add_nrsr;

  localparam int unsigned DW = 14;
  localparam int unsigned LN = 4;
  localparam int unsigned NT = 17;

  logic clk_72m = 1'b0;
  logic xreset;
  logic h_start, v_start, h_blank, v_blank;
  logic [LN-1:0][DW-1:0] pix_in;

  logic nr_hs, nr_vs, nr_hb, nr_vb;
  logic [LN-1:0][DW-1:0] nr_pix;
  logic by_hs, by_vs, by_hb, by_vb;
  logic [LN-1:0][DW-1:0] by_pix;

  int checks = 0;
  int errors = 0;

  always #7 clk_72m = ~clk_72m;

  add_nrsr #(.DATA_W(DW), .LANES(LN), .NR_EN(1'b1)) u_nr (
    .clk_72m          (clk_72m),
    .xreset           (xreset),
    .sens_h_start_in  (h_start),
    .sens_v_start_in  (v_start),
    .sens_h_blank_in  (h_blank),
    .sens_v_blank_in  (v_blank),
    .sens_pix_data_in (pix_in),
    .sens_h_start_out (nr_hs),
    .sens_v_start_out (nr_vs),
    .sens_h_blank_out (nr_hb),
    .sens_v_blank_out (nr_vb),
    .sens_pix_data_out(nr_pix)
  );

  add_nrsr #(.DATA_W(DW), .LANES(LN), .NR_EN(1'b0)) u_by (
    .clk_72m          (clk_72m),
    .xreset           (xreset),
    .sens_h_start_in  (h_start),
    .sens_v_start_in  (v_start),
    .sens_h_blank_in  (h_blank),
    .sens_v_blank_in  (v_blank),
    .sens_pix_data_in (pix_in),
    .sens_h_start_out (by_hs),
    .sens_v_start_out (by_vs),
    .sens_h_blank_out (by_hb),
    .sens_v_blank_out (by_vb),
    .sens_pix_data_out(by_pix)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LN-1:0][DW-1:0] pk(input int a, input int b, input int c,
                                               input int d);
    logic [LN-1:0][DW-1:0] r;
    r[0] = DW'(a);
    r[1] = DW'(b);
    r[2] = DW'(c);
    r[3] = DW'(d);
    return r;
  endfunction

  task automatic set_in(input logic hs, input logic vs, input logic hb, input logic vb,
                        input logic [LN-1:0][DW-1:0] d);
    h_start = hs;
    v_start = vs;
    h_blank = hb;
    v_blank = vb;
    pix_in  = d;
  endtask

  // Directed table: flags, input data and hand-computed filtered output
  logic                  t_hs [NT];
  logic                  t_vs [NT];
  logic                  t_hb [NT];
  logic                  t_vb [NT];
  logic [LN-1:0][DW-1:0] t_d  [NT];
  logic [LN-1:0][DW-1:0] t_e  [NT];

  task automatic row(input int i, input logic hs, input logic vs, input logic hb,
                     input logic vb, input logic [LN-1:0][DW-1:0] d,
                     input logic [LN-1:0][DW-1:0] e);
    t_hs[i] = hs; t_vs[i] = vs; t_hb[i] = hb; t_vb[i] = vb; t_d[i] = d; t_e[i] = e;
  endtask

  task automatic check_blank_idle(input string tag);
    check_val({tag, " nr_flags"}, {60'd0, nr_hs, nr_vs, nr_hb, nr_vb}, 64'h3);
    check_val({tag, " nr_data"}, 64'(nr_pix), 64'd0);
    check_val({tag, " by_flags"}, {60'd0, by_hs, by_vs, by_hb, by_vb}, 64'h3);
    check_val({tag, " by_data"}, 64'(by_pix), 64'd0);
  endtask

  // Random bypass history
  logic                  r_hs [64];
  logic                  r_vs [64];
  logic                  r_hb [64];
  logic                  r_vb [64];
  logic [LN-1:0][DW-1:0] r_e  [64];

  initial begin
    row(0,  0, 0, 1, 1, pk(0, 0, 0, 0),             pk(0, 0, 0, 0));
    row(1,  0, 1, 1, 1, pk(0, 0, 0, 0),             pk(0, 0, 0, 0));
    row(2,  1, 0, 1, 0, pk(9, 9, 9, 9),             pk(0, 0, 0, 0));
    row(3,  0, 0, 0, 0, pk(100, 200, 300, 400),     pk(100, 150, 250, 350));
    row(4,  0, 0, 0, 0, pk(500, 500, 500, 500),     pk(450, 500, 500, 500));
    row(5,  0, 0, 0, 0, pk(16383, 16383, 16383, 16383), pk(8442, 16383, 16383, 16383));
    row(6,  0, 0, 0, 0, pk(16383, 16383, 16382, 0), pk(16383, 16383, 16383, 8191));
    row(7,  0, 0, 1, 0, pk(1, 2, 3, 4),             pk(0, 0, 0, 0));
    row(8,  0, 0, 0, 0, pk(10, 20, 30, 40),         pk(10, 15, 25, 35));
    row(9,  1, 0, 1, 0, pk(0, 0, 0, 0),             pk(0, 0, 0, 0));
    row(10, 0, 0, 0, 0, pk(7, 7, 7, 7),             pk(7, 7, 7, 7));
    row(11, 0, 0, 0, 0, pk(20, 0, 1, 3),            pk(14, 10, 1, 2));
    row(12, 0, 0, 0, 1, pk(5, 5, 5, 5),             pk(0, 0, 0, 0));
    row(13, 0, 0, 0, 0, pk(30, 30, 30, 30),         pk(30, 30, 30, 30));
    row(14, 1, 1, 0, 0, pk(2, 4, 6, 8),             pk(2, 3, 5, 7));
    row(15, 0, 0, 1, 1, pk(0, 0, 0, 0),             pk(0, 0, 0, 0));
    row(16, 0, 0, 1, 1, pk(0, 0, 0, 0),             pk(0, 0, 0, 0));

    // Reset held 1 us with blanks high
    xreset = 1'b0;
    set_in(0, 0, 1, 1, '0);
    #1000;
    check_blank_idle("in_reset");
    @(negedge clk_72m);
    xreset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_72m);
      check_blank_idle("post_release");
    end

    // Directed table, outputs compared two cycles after each row is applied
    for (int i = 0; i < NT + 2; i++) begin
      @(negedge clk_72m);
      if (i >= 2) begin
        check_val($sformatf("flags_r%0d", i - 2), {60'd0, nr_hs, nr_vs, nr_hb, nr_vb},
                  {60'd0, t_hs[i-2], t_vs[i-2], t_hb[i-2], t_vb[i-2]});
        check_val($sformatf("nr_data_r%0d", i - 2), 64'(nr_pix), 64'(t_e[i-2]));
        check_val($sformatf("by_data_r%0d", i - 2), 64'(by_pix),
                  (t_hb[i-2] || t_vb[i-2]) ? 64'd0 : 64'(t_d[i-2]));
      end
      if (i < NT) set_in(t_hs[i], t_vs[i], t_hb[i], t_vb[i], t_d[i]);
      else        set_in(0, 0, 1, 1, '0);
    end

    // Mid-line asynchronous reset discards the held lane
    set_in(0, 0, 0, 0, pk(100, 100, 100, 100));
    @(negedge clk_72m);
    set_in(0, 0, 0, 0, pk(200, 200, 200, 200));
    @(posedge clk_72m);
    #3;
    xreset = 1'b0;
    #1;
    check_blank_idle("async_assert");
    @(negedge clk_72m);
    xreset = 1'b1;
    set_in(0, 0, 0, 0, pk(50, 60, 70, 80));
    @(negedge clk_72m);
    set_in(0, 0, 1, 1, '0);
    @(negedge clk_72m);
    check_val("after_reset_line_start", 64'(nr_pix), 64'(pk(50, 55, 65, 75)));

    // Bypass instance: random data with blanking gaps
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_72m);
      if (i >= 2) begin
        check_val($sformatf("by_rand_flags_%0d", i - 2), {60'd0, by_hs, by_vs, by_hb, by_vb},
                  {60'd0, r_hs[i-2], r_vs[i-2], r_hb[i-2], r_vb[i-2]});
        check_val($sformatf("by_rand_data_%0d", i - 2), 64'(by_pix), 64'(r_e[i-2]));
      end
      r_hs[i] = ($urandom_range(0, 7) == 0);
      r_vs[i] = ($urandom_range(0, 15) == 0);
      r_hb[i] = ($urandom_range(0, 3) == 0);
      r_vb[i] = ($urandom_range(0, 7) == 0);
      set_in(r_hs[i], r_vs[i], r_hb[i], r_vb[i],
             pk($urandom_range(0, 16383), $urandom_range(0, 16383),
                $urandom_range(0, 16383), $urandom_range(0, 16383)));
      r_e[i] = (r_hb[i] || r_vb[i]) ? '0 : pix_in;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
